// File: rtl/div_seq_8bit.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, N-cycle latency.
// Optional macro DIV_SEQ_8BIT_ZERO_DETECT_EN short-circuits divide-by-zero with a flag.
module div_seq_8bit #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  remo_q, remo_d;
    logic          done_q, done_d;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          qbit;
`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
    logic          dbz_q, dbz_d;
    logic          zero_pend_q, zero_pend_d;
`endif

    // Working partial remainder is N+1 bits; the sign bit of the trial decides restore.
    assign shifted = {rem_q, dvd_q[N-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign qbit    = ~trial[N];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
        dbz_d       = dbz_q;
        zero_pend_d = zero_pend_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
                if (zero_pend_q) begin
                    // Zero divisor latched last edge: publish the result without iterating.
                    quot_d      = '1;
                    remo_d      = dvd_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    zero_pend_d = 1'b0;
                    state_d     = StDone;
                end else if (i_start) begin
                    rem_d = '0;
                    dvd_d = i_dividend;
                    dvs_d = i_divisor;
                    cnt_d = '0;
                    if (i_divisor == '0) begin
                        zero_pend_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end
`else
                if (i_start) begin
                    rem_d   = '0;
                    dvd_d   = i_dividend;
                    dvs_d   = i_divisor;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
`endif
            end
            StCalc: begin
                rem_d = qbit ? trial[N-1:0] : shifted[N-1:0];
                dvd_d = {dvd_q[N-2:0], qbit};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    quot_d  = {dvd_q[N-2:0], qbit};
                    remo_d  = qbit ? trial[N-1:0] : shifted[N-1:0];
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
                    dbz_d = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
        end
    end

`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dbz_q       <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            dbz_q       <= dbz_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign o_div_by_zero = dbz_q;
`else
    assign o_div_by_zero = 1'b0;
`endif

    assign o_busy      = (state_q == StCalc);
    assign o_done      = done_q;
    assign o_quotient  = quot_q;
    assign o_remainder = remo_q;

endmodule

// File: tb/tb_div_seq_8bit.sv
// Self-checking bench for div_seq_8bit: vector table plus scoreboard, with hand-written
// sequences for start-while-busy, back-to-back issue from DONE and mid-run reset.
module tb_div_seq_8bit;

    localparam int N = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;
    logic         o_div_by_zero;

    div_seq_8bit #(.N(N)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
        int           busy;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   elapsed;
    int   busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        elapsed++;
        if (o_busy) busy_cnt++;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic [N-1:0] r);
        exp_t e;
        @(negedge i_clk);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        e.q = q;
        e.r = r;
`ifdef DIV_SEQ_8BIT_ZERO_DETECT_EN
        e.dbz  = (b == 0);
        e.lat  = (b == 0) ? 1 : N;
        e.busy = (b == 0) ? 0 : N;
`else
        e.dbz  = 1'b0;
        e.lat  = N;
        e.busy = N;
`endif
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        i_start    = 1'b0;
        // Scramble operands to show they were latched.
        i_dividend = N'($urandom);
        i_divisor  = N'($urandom);
        elapsed    = 0;
        busy_cnt   = o_busy ? 1 : 0;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        while (!o_done && elapsed < 20) step();
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            if (!o_done) begin
                check({tag, " timeout"}, 0, 1);
            end else begin
                check({tag, " latency"}, elapsed, e.lat);
                check({tag, " quotient"}, o_quotient, e.q);
                check({tag, " remainder"}, o_remainder, e.r);
                check({tag, " div_by_zero"}, o_div_by_zero, e.dbz);
                check({tag, " busy_cycles"}, busy_cnt, e.busy);
            end
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
        vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
        vecs[4] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100};
        vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
        vecs[6] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2};
        vecs[7] = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14};
        vecs[8] = '{a: 8'd17,  b: 8'd17,  q: 8'd1,   r: 8'd0};

        i_rst      = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #3;
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset quotient", o_quotient, 0);
        check("reset remainder", o_remainder, 0);
        check("reset div_by_zero", o_div_by_zero, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
            collect($sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d done_width", i), o_done, 0);
        end

        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(1, 255));
            issue(a, b, a / b, a % b);
            collect($sformatf("rand%0d", i));
        end

        // Start while busy is ignored; then a new start in DONE begins with no idle cycle.
        step();
        issue(8'd200, 8'd7, 8'd28, 8'd4);
        step();
        step();
        i_start    = 1'b1;
        i_dividend = 8'd50;
        i_divisor  = 8'd3;
        step();
        i_start = 1'b0;
        collect("busy_ignore");
        issue(8'd50, 8'd3, 8'd16, 8'd2);
        check("b2b busy_after_start", busy_cnt, 1);
        collect("b2b");

        // Asynchronous reset between edges aborts the run.
        step();
        issue(8'd200, 8'd7, 8'd28, 8'd4);
        step();
        step();
        #2;
        i_rst = 1'b0;
        #1;
        check("midreset busy", o_busy, 0);
        check("midreset done", o_done, 0);
        check("midreset quotient", o_quotient, 0);
        check("midreset remainder", o_remainder, 0);
        check("midreset div_by_zero", o_div_by_zero, 0);
        void'(sb.pop_front());
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (o_done) seen++;
            end
            check("midreset no_done", seen, 0);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        issue(8'd9, 8'd2, 8'd4, 8'd1);
        collect("post_reset");
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (o_done) seen++;
            end
            check("idle no_spurious_done", seen, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_seq_8bit.md
DIV_SEQ_8BIT -- requirements
Module: div_seq_8bit

Interface
REQ-001 SHALL provide parameter: N, default 8, operand/result width in bits.
REQ-002 SHALL provide port: i_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port: i_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: i_start  input  1  request a division; sampled only when o_busy=0.
REQ-005 SHALL provide port: i_dividend  input  N  unsigned dividend, sampled with i_start.
REQ-006 SHALL provide port: i_divisor  input  N  unsigned divisor, sampled with i_start.
REQ-007 SHALL provide port: o_busy  output  1  high while a division is in progress.
REQ-008 SHALL provide port: o_done  output  1  registered one-cycle pulse marking valid results.
REQ-009 SHALL provide port: o_quotient  output  N  registered unsigned quotient.
REQ-010 SHALL provide port: o_remainder  output  N  registered unsigned remainder.
REQ-011 SHALL provide port: o_div_by_zero  output  1  registered flag, divisor was zero (see Configuration).

Function
REQ-012 SHALL implement a restoring shift-subtract divider (inverse of the add/sub accumulator): one quotient bit per clock, MSB first.
REQ-013 SHALL use FSM states IDLE, CALC, DONE; IDLE->CALC on i_start=1; CALC->DONE after N iterations; DONE->IDLE next cycle, or DONE->CALC if i_start=1 in DONE.
REQ-014 SHALL latch i_dividend and i_divisor on the edge that samples i_start; later operand changes SHALL NOT affect the running operation.
REQ-015 SHALL use an N+1-bit partial remainder: each iteration shift {rem, next dividend bit} left, trial-subtract divisor; non-negative result kept with quotient bit 1, else restore with quotient bit 0.
REQ-016 SHALL register o_quotient/o_remainder and raise o_done at the N-th rising edge after the edge that sampled i_start (latency N cycles), o_done high exactly one cycle.
REQ-017 SHALL hold o_quotient, o_remainder, o_div_by_zero stable from o_done until the edge at which the next i_start is sampled.
REQ-018 SHALL drive o_busy=1 in CALC only; i_start while o_busy=1 SHALL be ignored without side effects.
REQ-019 SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for every nonzero divisor including dividend < divisor (quotient 0) and divisor 1.

Reset
REQ-020 SHALL on i_rst=0, immediately and regardless of clock, force state IDLE, o_busy=0, o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0 and clear internal registers.
REQ-021 SHALL abort any in-progress division on reset with no o_done pulse; the first i_start after deassertion SHALL start a fresh operation.

Configuration
REQ-022 SHALL recognize macro DIV_SEQ_8BIT_ZERO_DETECT_EN.
REQ-023 SHALL, with the macro defined, on divisor=0 skip CALC: at the first edge after start sampling register o_quotient=all ones, o_remainder=dividend, o_div_by_zero=1, o_done=1 (latency 1).
REQ-024 SHALL, without the macro, run the normal N-cycle algorithm for divisor=0 (yielding quotient all ones, remainder=dividend) and tie o_div_by_zero to 0.
REQ-025 SHALL clear o_div_by_zero on every result with nonzero divisor.

Verification
REQ-026 SHALL cover: reset, i_start=1 with 200/7 -> o_done pulse 8 cycles later, o_quotient=28, o_remainder=4, o_busy high 8 cycles.
REQ-027 SHALL cover: 255/1 -> 255 rem 0; 5/9 -> 0 rem 5; 255/255 -> 1 rem 0; each latency 8.
REQ-028 SHALL cover: 100/0 with macro -> o_done after 1 cycle, q=255, r=100, o_div_by_zero=1; without macro -> after 8 cycles, q=255, r=100, flag 0.
REQ-029 SHALL cover: i_start pulsed with 50/3 during a running 200/7 -> ignored, result 28 rem 4, then 50/3 issued in DONE -> 16 rem 2 with no idle cycle.
REQ-030 SHALL cover: i_rst=0 asserted mid-CALC between clock edges -> outputs zero immediately, no o_done; after release 9/2 -> 4 rem 1.
